// File: rtl/ntt_params.sv
// Shared constants, state encoding and elaboration-time helpers for the NTT array.
package ntt_params;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_Q     = 7681;
  localparam int unsigned DEF_W     = 7098;
  localparam int unsigned DEF_W_INV = 7154;
  localparam int unsigned DEF_N_INV = 7201;

  // Number of bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // base^exp mod q by repeated multiplication; used only at elaboration.
  function automatic int unsigned modpow(input int unsigned base, input int unsigned exp,
                                         input int unsigned q);
    longint unsigned r;
    longint unsigned b;
    r = 1 % q;
    b = base % q;
    for (int unsigned i = 0; i < exp; i++) r = (r * b) % q;
    return 32'(r);
  endfunction

endpackage

// File: rtl/ntt_pe.sv
// One systolic stage: holds x[J], adds x[J]*w^(J*k) into the travelling accumulator.
module ntt_pe
  import ntt_params::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned W_INV = DEF_W_INV,
  parameter int unsigned J     = 0,
  localparam int unsigned DW   = clog2(Q),
  localparam int unsigned LW   = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic          i_coef_we,
  input  logic [DW-1:0] i_coef,
  input  logic          i_mode_inv,
  input  logic          i_valid,
  input  logic [LW-1:0] i_k,
  input  logic [DW-1:0] i_acc,
  output logic          o_valid,
  output logic [LW-1:0] o_k,
  output logic [DW-1:0] o_acc
);

  // Twiddle table T[i] = W^i mod Q; the last entry is W^(N-1), which is W_INV.
  function automatic logic [N*DW-1:0] build_tbl();
    logic [N*DW-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < N; i++)
      t[i*DW +: DW] = (i == N - 1) ? DW'(W_INV % Q) : DW'(modpow(W, i, Q));
    return t;
  endfunction

  localparam logic [N*DW-1:0] T_FLAT = build_tbl();
  localparam logic [LW-1:0]   J_L    = LW'(J);

  logic [DW-1:0]   r_coef;
  logic [LW-1:0]   w_e;
  logic [LW-1:0]   w_idx;
  logic [DW-1:0]   w_tw;
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_prod_mod;
  logic [DW:0]     w_sum;
  logic [DW-1:0]   w_sum_mod;

  // Exponent (J*k) mod N, negated mod N for the inverse transform, then multiply-add mod Q.
  always_comb begin
    w_e        = i_k * J_L;
    w_idx      = i_mode_inv ? (LW'(0) - w_e) : w_e;
    w_tw       = T_FLAT[w_idx*DW +: DW];
    w_prod     = (2*DW)'(r_coef) * (2*DW)'(w_tw);
    w_prod_mod = DW'(w_prod % (2*DW)'(Q));
    w_sum      = (DW+1)'(i_acc) + (DW+1)'(w_prod_mod);
    w_sum_mod  = (w_sum >= (DW+1)'(Q)) ? DW'(w_sum - (DW+1)'(Q)) : DW'(w_sum);
  end

  // Coefficient register, written once per transform during LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_coef <= '0;
    else if (i_coef_we) r_coef <= i_coef;
  end

  // Stage pipeline registers, frozen together with every other stage when i_adv is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_k     <= '0;
      o_acc   <= '0;
    end else if (i_adv) begin
      o_valid <= i_valid;
      o_k     <= i_k;
      o_acc   <= w_sum_mod;
    end
  end

endmodule

// File: rtl/ntt_stream_array.sv
// N-stage systolic NTT: load N coefficients, stream N results with backpressure, re-arm.
module ntt_stream_array
  import ntt_params::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned W_INV = DEF_W_INV,
  parameter int unsigned N_INV = DEF_N_INV,
  localparam int unsigned DW   = clog2(Q),
  localparam int unsigned LW   = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_data,
  input  logic          mode_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [LW-1:0] out_index,
  output logic          out_last,
  output logic          busy
);

  state_t          r_state;
  logic            r_load_ready;
  logic            r_busy;
  logic            r_mode;
  logic [LW-1:0]   r_load_cnt;
  logic [LW-1:0]   r_issue_k;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic [LW-1:0]   r_out_index;
  logic            r_out_last;

  logic            w_adv;
  logic            w_load_hs;
  logic            w_last_hs;
  logic [DW-1:0]   w_load_mod;
  logic [2*DW-1:0] w_scaled;
  logic [DW-1:0]   w_scaled_mod;

  logic            w_v   [N];
  logic [LW-1:0]   w_k   [N];
  logic [DW-1:0]   w_acc [N];

  // Shared advance enable, handshakes, input reduction and final scaling.
  always_comb begin
    w_adv        = !r_out_valid || out_ready;
    w_load_hs    = load_valid && r_load_ready;
    w_last_hs    = r_out_valid && out_ready && r_out_last;
    w_load_mod   = load_data % DW'(Q);
    w_scaled     = (2*DW)'(w_acc[N-1]) * (r_mode ? (2*DW)'(N_INV) : (2*DW)'(1));
    w_scaled_mod = DW'(w_scaled % (2*DW)'(Q));
  end

  for (genvar j = 0; j < N; j++) begin : g_pe
    if (j == 0) begin : g_first
      ntt_pe #(.N(N), .Q(Q), .W(W), .W_INV(W_INV), .J(j)) u_pe (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (w_adv),
        .i_coef_we  (w_load_hs && (r_load_cnt == LW'(j))),
        .i_coef     (w_load_mod),
        .i_mode_inv (r_mode),
        .i_valid    (r_state == ISSUE),
        .i_k        (r_issue_k),
        .i_acc      ('0),
        .o_valid    (w_v[j]),
        .o_k        (w_k[j]),
        .o_acc      (w_acc[j])
      );
    end else begin : g_rest
      ntt_pe #(.N(N), .Q(Q), .W(W), .W_INV(W_INV), .J(j)) u_pe (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (w_adv),
        .i_coef_we  (w_load_hs && (r_load_cnt == LW'(j))),
        .i_coef     (w_load_mod),
        .i_mode_inv (r_mode),
        .i_valid    (w_v[j-1]),
        .i_k        (w_k[j-1]),
        .i_acc      (w_acc[j-1]),
        .o_valid    (w_v[j]),
        .o_k        (w_k[j]),
        .o_acc      (w_acc[j])
      );
    end
  end

  // Control FSM: LOAD coefficients, ISSUE k=0..N-1 into stage 0, DRAIN until the last result leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_load_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_mode       <= 1'b0;
      r_load_cnt   <= '0;
      r_issue_k    <= '0;
    end else begin
      unique case (r_state)
        LOAD: if (w_load_hs) begin
          if (r_load_cnt == '0) r_mode <= mode_inv;
          if (r_load_cnt == LW'(N - 1)) begin
            r_load_cnt   <= '0;
            r_issue_k    <= '0;
            r_state      <= ISSUE;
            r_load_ready <= 1'b0;
            r_busy       <= 1'b1;
          end else begin
            r_load_cnt <= r_load_cnt + 1'b1;
          end
        end
        ISSUE: if (w_adv) begin
          if (r_issue_k == LW'(N - 1)) begin
            r_issue_k <= '0;
            r_state   <= DRAIN;
          end else begin
            r_issue_k <= r_issue_k + 1'b1;
          end
        end
        DRAIN: if (w_last_hs) begin
          r_state      <= LOAD;
          r_load_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  // Output register stage, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_v[N-1];
      r_out_data  <= w_scaled_mod;
      r_out_index <= w_k[N-1];
      r_out_last  <= w_v[N-1] && (w_k[N-1] == LW'(N - 1));
    end
  end

  // Port drive from registered state.
  always_comb begin
    load_ready = r_load_ready;
    busy       = r_busy;
    out_valid  = r_out_valid;
    out_data   = r_out_data;
    out_index  = r_out_index;
    out_last   = r_out_last;
  end

endmodule

// File: tb/tb_ntt_stream_array.sv
// Directed, table-driven bench for ntt_stream_array (default 16-point and an 8-point/Q=17 instance).
module tb_ntt_stream_array;

  localparam int unsigned NA = 16, QA = 7681, WA = 7098, WIA = 7154, NIA = 7201;
  localparam int unsigned NB = 8,  QB = 17,   WB = 2,    WIB = 9,    NIB = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_load_valid, a_load_ready, a_mode_inv, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [12:0] a_load_data, a_out_data;
  logic [3:0]  a_out_index;
  logic        b_load_valid, b_load_ready, b_mode_inv, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [4:0]  b_load_data, b_out_data;
  logic [2:0]  b_out_index;

  ntt_stream_array u_dut_a (
    .clk(clk), .rst(rst),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data), .mode_inv(a_mode_inv),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_index(a_out_index),
    .out_last(a_out_last), .busy(a_busy)
  );

  ntt_stream_array #(.N(NB), .Q(QB), .W(WB), .W_INV(WIB), .N_INV(NIB)) u_dut_b (
    .clk(clk), .rst(rst),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data), .mode_inv(b_mode_inv),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_index(b_out_index),
    .out_last(b_out_last), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  bit          sel = 1'b0;  // 0: 16-point instance, 1: 8-point instance
  logic        m_valid, m_last, m_lready, m_busy;
  int unsigned m_data, m_index;

  always_comb begin
    if (sel) begin
      m_valid = b_out_valid; m_last = b_out_last; m_lready = b_load_ready; m_busy = b_busy;
      m_data = 32'(b_out_data); m_index = 32'(b_out_index);
    end else begin
      m_valid = a_out_valid; m_last = a_out_last; m_lready = a_load_ready; m_busy = a_busy;
      m_data = 32'(a_out_data); m_index = 32'(a_out_index);
    end
  end

  typedef struct {
    bit          inv;
    int unsigned x  [16];
    int          sk [4];
    int unsigned sv [4];
    int          stall_k;
    int          stall_len;
    bit          rnd;
    bit          hold999;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_load(input logic v, input int unsigned d, input logic inv);
    if (sel) begin b_load_valid = v; b_load_data = 5'(d);  b_mode_inv = inv; end
    else     begin a_load_valid = v; a_load_data = 13'(d); a_mode_inv = inv; end
  endtask

  task automatic drive_ready(input logic r);
    if (sel) b_out_ready = r; else a_out_ready = r;
  endtask

  // Direct DFT reference: sum x[j]*base^(jk), base = W or W_INV, scaled by N_INV when inverse.
  function automatic int unsigned ref_x(input int unsigned xs[16], input bit inv, input int unsigned k);
    longint unsigned n, q, base, step, p, acc;
    n    = sel ? NB : NA;
    q    = sel ? QB : QA;
    base = inv ? (sel ? WIB : WIA) : (sel ? WB : WA);
    step = 1;
    for (int unsigned i = 0; i < k; i++) step = step * base % q;
    p = 1; acc = 0;
    for (int unsigned j = 0; j < n; j++) begin
      acc = (acc + (xs[j] % q) * p) % q;
      p   = p * step % q;
    end
    if (inv) acc = acc * (sel ? NIB : NIA) % q;
    return 32'(acc);
  endfunction

  // Mode is driven to the opposite value after j=0 so that only the first handshake may capture it.
  task automatic load_vec(input int unsigned xs[16], input bit inv);
    int unsigned n;
    n = sel ? NB : NA;
    for (int unsigned j = 0; j < n; j++) begin
      @(negedge clk);
      drive_load(1'b1, xs[j], (j == 0) ? inv : !inv);
      check($sformatf("load_ready j=%0d", j), m_lready, 1);
      @(posedge clk);
    end
  endtask

  task automatic run_out(input int unsigned xs[16], input bit inv, input int stall_k, input int stall_len,
                         input bit rnd, input bit hold999, input int sk[4], input int unsigned sv[4]);
    int unsigned n, got, iter, stalls, first_iter, pd, pi;
    int  rem;
    bit  stall_done, prev_hold;
    logic pl, rdy;
    n = sel ? NB : NA;
    got = 0; iter = 0; stalls = 0; first_iter = 0; pd = 0; pi = 0;
    rem = 0; stall_done = 0; prev_hold = 0; pl = 0;
    while (got < n && iter < 4 * n + 200) begin
      @(negedge clk);
      iter++;
      if (hold999) drive_load(1'b1, 999, 1'b0);
      else         drive_load(1'b0, 0, 1'b0);
      if (hold999) check("load_ready while busy", m_lready, 0);
      if (iter == 1) check("busy in ISSUE", m_busy, 1);
      if (prev_hold) begin
        check("stall valid held", m_valid, 1);
        check("stall data held", m_data, pd);
        check("stall index held", m_index, pi);
        check("stall last held", m_last, pl);
      end
      if (m_valid && first_iter == 0) begin
        first_iter = iter;
        check("first result latency", iter, n + 2);
      end
      rdy = 1'b1;
      if (m_valid) begin
        if (!stall_done && stall_len > 0 && int'(m_index) == stall_k) begin
          rem = stall_len; stall_done = 1;
        end
        if (rem > 0) begin rdy = 1'b0; rem--; end
        else if (rnd && $urandom_range(0, 3) == 0) rdy = 1'b0;
        if (!rdy) stalls++;
      end
      drive_ready(rdy);
      prev_hold = m_valid && !rdy;
      pd = m_data; pi = m_index; pl = m_last;
      if (m_valid && rdy) begin
        check($sformatf("out_index #%0d", got), m_index, got);
        check($sformatf("out_data k=%0d", got), m_data, ref_x(xs, inv, got));
        check($sformatf("out_last k=%0d", got), m_last, (got == n - 1) ? 1 : 0);
        for (int i = 0; i < 4; i++)
          if (sk[i] == int'(got)) check($sformatf("hand value k=%0d", got), m_data, sv[i]);
        got++;
      end
      @(posedge clk);
    end
    if (got < n) check("results before timeout", got, n);
    check("transform cycles", iter, 2 * n + 1 + stalls);
    @(negedge clk);
    drive_load(1'b0, 0, 1'b0);
    drive_ready(1'b1);
    check("load_ready after last", m_lready, 1);
    check("busy after last", m_busy, 0);
    check("out_valid after last", m_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned xb [16];
    int          skb [4];
    int unsigned svb [4];

    a_load_valid = 0; a_load_data = '0; a_mode_inv = 0; a_out_ready = 1;
    b_load_valid = 0; b_load_data = '0; b_mode_inv = 0; b_out_ready = 1;

    for (int i = 0; i < 6; i++) begin
      tv[i].inv = 0; tv[i].x = '{default: 0}; tv[i].stall_k = -1; tv[i].stall_len = 0;
      tv[i].rnd = 0; tv[i].hold999 = 0; tv[i].sk = '{0, 0, 0, 0}; tv[i].sv = '{0, 0, 0, 0};
    end
    tv[0].x[0] = 1;                  tv[0].sk = '{0, 7, 15, 3};  tv[0].sv = '{1, 1, 1, 1};
    tv[1].x[1] = 1;                  tv[1].sk = '{1, 2, 8, 15};  tv[1].sv = '{7098, 1925, 7680, 7154};
    tv[1].stall_k = 3; tv[1].stall_len = 5;
    tv[2].inv = 1; tv[2].x[0] = 16; tv[2].sk = '{0, 5, 9, 15};  tv[2].sv = '{1, 1, 1, 1}; tv[2].rnd = 1;
    tv[3].x = '{default: 1};         tv[3].sk = '{0, 1, 8, 15};  tv[3].sv = '{16, 0, 0, 0}; tv[3].hold999 = 1;
    tv[4].inv = 1; tv[4].x[1] = 1;  tv[4].sk = '{0, 8, 4, 12};  tv[4].sv = '{7201, 480, 3149, 4532};
    tv[5].x[0] = 7686;               tv[5].sk = '{0, 9, 15, 1};  tv[5].sv = '{5, 5, 5, 5}; tv[5].rnd = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset load_ready", a_load_ready, 1);
    check("reset out_valid", a_out_valid, 0);
    check("reset out_data", a_out_data, 0);
    check("reset out_index", a_out_index, 0);
    check("reset out_last", a_out_last, 0);
    check("reset busy", a_busy, 0);

    for (int i = 0; i < 6; i++) begin
      load_vec(tv[i].x, tv[i].inv);
      run_out(tv[i].x, tv[i].inv, tv[i].stall_k, tv[i].stall_len, tv[i].rnd, tv[i].hold999,
              tv[i].sk, tv[i].sv);
    end

    // Reset during ISSUE.
    load_vec(tv[1].x, 1'b0);
    @(negedge clk);
    drive_load(1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("busy before ISSUE reset", a_busy, 1);
    rst = 1;
    #1;
    check("ISSUE reset busy", a_busy, 0);
    check("ISSUE reset load_ready", a_load_ready, 1);
    check("ISSUE reset out_valid", a_out_valid, 0);
    @(negedge clk);
    rst = 0;
    load_vec(tv[4].x, tv[4].inv);
    run_out(tv[4].x, tv[4].inv, -1, 0, 0, 0, tv[4].sk, tv[4].sv);

    // Reset while results are streaming.
    load_vec(tv[1].x, 1'b0);
    @(negedge clk);
    drive_load(1'b0, 0, 1'b0);
    repeat (19) @(negedge clk);
    check("valid before DRAIN reset", a_out_valid, 1);
    rst = 1;
    #1;
    check("DRAIN reset out_valid", a_out_valid, 0);
    check("DRAIN reset out_index", a_out_index, 0);
    check("DRAIN reset out_data", a_out_data, 0);
    check("DRAIN reset load_ready", a_load_ready, 1);
    @(negedge clk);
    rst = 0;

    // Partial load aborted by reset; the next full load must start again at j=0.
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      drive_load(1'b1, 1234, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    drive_load(1'b0, 0, 1'b0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    load_vec(tv[1].x, 1'b0);
    run_out(tv[1].x, 1'b0, -1, 0, 0, 0, tv[1].sk, tv[1].sv);

    // 8-point instance, Q=17.
    sel = 1'b1;
    xb = '{default: 0};
    xb[0] = 3; xb[1] = 1; xb[2] = 4; xb[3] = 1; xb[4] = 5; xb[5] = 9; xb[6] = 2; xb[7] = 6;
    skb = '{0, 4, 0, 4};
    svb = '{14, 14, 14, 14};
    load_vec(xb, 1'b0);
    run_out(xb, 1'b0, -1, 0, 0, 0, skb, svb);
    svb = '{6, 6, 6, 6};
    load_vec(xb, 1'b1);
    run_out(xb, 1'b1, 2, 3, 1, 0, skb, svb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_stream_array.md
# ntt_stream_array

Parametrised successor to the fixed 16-point systolic NTT array: an N-stage linear systolic pipeline that computes X[k] = Σ x[j]·ω^(jk) mod Q, forward or inverse, for any power-of-two N and prime Q. Coefficients are loaded through a valid/ready port. The block then streams all N outputs through a valid/ready port, with full backpressure, and re-arms automatically for the next transform. It sits between the coefficient buffer and the result FIFO in the NTT datapath.

## Interface
- N, 16, transform length, power of two, ≥2
- Q, 7681, prime modulus, N divides Q−1
- W, 7098, primitive N-th root of unity mod Q
- W_INV, 7154, W^(N−1) mod Q
- N_INV, 7201, N^(−1) mod Q
- DW, derived localparam: $clog2(Q); LW = $clog2(N)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_valid  in  1  coefficient valid
- load_ready  out  1  block accepts a coefficient
- load_data  in  DW  coefficient x[j]; j is the implicit arrival order 0..N−1
- mode_inv  in  1  0 = forward, 1 = inverse; sampled with the j=0 handshake
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  X[k], range 0..Q−1
- out_index  out  LW  k
- out_last  out  1  high with k = N−1
- busy  out  1  high in ISSUE and DRAIN

## Operation
- Reset values: load_ready=1 after release, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0. Load counter, issue counter and all PE coefficient registers are cleared; mode is cleared to forward.
- States:
  - LOAD: load_ready=1. Each handshake writes (load_data mod Q) into PE j and increments j. The handshake at j=N−1 moves the FSM to ISSUE.
  - ISSUE: injects k=0..N−1 into PE0, one k per advancing cycle. After k=N−1 is injected, the FSM moves to DRAIN.
  - DRAIN: waits for the out_last handshake, then returns to LOAD with j=0.
- load_ready=0 in ISSUE and DRAIN. A load_valid seen in those states is ignored and nothing is written.
- PE j computes acc_out = (acc_in + x[j]·T[e]) mod Q, passes k through unchanged, and stays aligned with its stage.
  - e = (j·k) mod N, i.e. the low LW bits of the product.
  - In inverse mode the exponent is (N−e) mod N.
- T is the twiddle table T[i] = W^i mod Q. It is built at elaboration by a constant function; no runtime load is needed.
- Final stage: out_data = acc·(mode_inv ? N_INV : 1) mod Q, registered.
- Arithmetic:
  - Products are formed at 2·DW bits and reduced with % Q.
  - Additions are done at DW+1 bits with one conditional subtraction of Q.
  - No output value is ever ≥ Q.
- Pipeline advance: adv = !out_valid || out_ready.
  - Every stage, including the issue counter, updates only when adv=1.
  - When adv=0, all stage registers and the outputs hold.

## Timing
- Let t0 be the first ISSUE cycle, which is the cycle after the j=N−1 load handshake.
- With no stalls:
  - k=0 is presented to PE0 in cycle t0.
  - out_valid for k=0 is high in cycle t0+N+1.
  - k=N−1 appears in cycle t0+2N.
- Each cycle with adv=0 adds exactly one cycle of latency to every in-flight result. No result is lost or duplicated.
- load_ready goes high in the cycle after the out_last handshake.
- Back-to-back transforms: the next load overlaps nothing, so one transform takes N + 2N + 1 cycles minimum.
- out_valid never deasserts without a handshake; out_data, out_index and out_last hold stable while out_valid=1 and out_ready=0.
- rst asserted at any point (mid-load, mid-issue or mid-drain) aborts immediately to the reset values. A partially loaded vector is discarded.

## Structure
- Shared package/include ntt_params holds:
  - constant functions modpow(base, exp, Q) and clog2;
  - state encodings LOAD/ISSUE/DRAIN;
  - default N/Q/W/W_INV/N_INV.
- Sub-module ntt_pe, instantiated N times via generate. It contains the coefficient register, twiddle lookup, modular multiply-add and the k/acc pipeline registers. All PEs share the adv enable.
- The top level holds the FSM, the counters, the scale stage and the output registers.

## Test plan
- Forward transform of x=[1,0,…,0] with defaults: all 16 outputs are 1, out_index runs 0..15, and out_last is high only at k=15.
- Forward transform of x=[0,1,0,…,0]: out_data[k]=W^k, checked as out[1]=7098, out[2]=1925, out[8]=7680, out[15]=7154.
- Inverse transform of x=[16,0,…,0]: all outputs are 1. Forward transform of all-ones: out[0]=16, all others 0.
- Backpressure: drop out_ready for 5 cycles at k=3 and at random points. Outputs must hold stable and match the golden model; the total cycle count grows by exactly the number of stall cycles.
- load_valid held high during ISSUE/DRAIN with value 999: load_ready=0, and the next transform's results are unaffected.
- rst pulsed mid-ISSUE, followed by a fresh load: out_valid drops immediately, and the next transform is correct. A final run with N=8, Q=17, W=2 (N_INV=15, W_INV=9) matches the golden model.
